// File: rtl/sha256_sched_ctrl_if.sv
// Handshake bundle between the SHA-256 schedule controller, its message source and the round engine.
// Bulk-load pins exist only when SHA256_SCHED_BULK_LOAD_EN is defined.
interface sha256_sched_ctrl_if;
   logic         i_start;
   logic [31:0]  i_m;
   logic         i_m_valid;
   logic         o_m_ready;
   logic [31:0]  o_w;
   logic         o_w_valid;
   logic         i_w_ready;
   logic [5:0]   o_t;
   logic         o_last;
   logic         o_busy;
   logic         o_done;
`ifdef SHA256_SCHED_BULK_LOAD_EN
   logic [511:0] i_block;
   logic         i_block_valid;

   modport slave (
      input  i_start, i_m, i_m_valid, i_w_ready, i_block, i_block_valid,
      output o_m_ready, o_w, o_w_valid, o_t, o_last, o_busy, o_done
   );
   modport master (
      output i_start, i_m, i_m_valid, i_w_ready, i_block, i_block_valid,
      input  o_m_ready, o_w, o_w_valid, o_t, o_last, o_busy, o_done
   );
`else
   modport slave (
      input  i_start, i_m, i_m_valid, i_w_ready,
      output o_m_ready, o_w, o_w_valid, o_t, o_last, o_busy, o_done
   );
   modport master (
      output i_start, i_m, i_m_valid, i_w_ready,
      input  o_m_ready, o_w, o_w_valid, o_t, o_last, o_busy, o_done
   );
`endif
endinterface

// File: rtl/sha256_sched_ctrl.sv
// SHA-256 message-schedule controller: 16-word sliding window emitting W0..W(ROUNDS-1).
// Optional single-cycle block load is enabled by defining SHA256_SCHED_BULK_LOAD_EN.
module sha256_sched_ctrl #(
   parameter int ROUNDS = 64
) (
   input  logic               i_clk,
   input  logic               i_rst,
   sha256_sched_ctrl_if.slave bus,
   output logic [1:0]         o_state
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

   localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

   state_t      state, state_nxt;
   logic [31:0] win [16];
   logic [3:0]  ld_cnt;
   logic [5:0]  t_cnt;
   logic        m_fire, bulk_fire, pop, at_last;
   logic [31:0] w_next;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // A transfer happens on a rising edge where valid and ready are both high;
   // valid never waits on ready, and o_w/o_t hold steady until the transfer.
   assign m_fire  = (state == S_LOAD) && bus.i_m_valid;
`ifdef SHA256_SCHED_BULK_LOAD_EN
   assign bulk_fire = (state == S_LOAD) && bus.i_block_valid;
`else
   assign bulk_fire = 1'b0;
`endif
   assign pop     = (state == S_STREAM) && bus.i_w_ready;
   assign at_last = (t_cnt == LAST_T);
   assign w_next  = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
   assign o_state = state;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.o_m_ready = 1'b0;
      bus.o_w_valid = 1'b0;
      bus.o_w       = '0;
      bus.o_t       = '0;
      bus.o_last    = 1'b0;
      bus.o_busy    = 1'b0;
      bus.o_done    = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.i_start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            bus.o_m_ready = 1'b1;
            bus.o_busy    = 1'b1;
            if (bulk_fire || (m_fire && ld_cnt == 4'd15)) state_nxt = S_STREAM;
         end
         S_STREAM: begin
            bus.o_w_valid = 1'b1;
            bus.o_busy    = 1'b1;
            bus.o_w       = win[0];
            bus.o_t       = t_cnt;
            bus.o_last    = at_last;
            if (pop && at_last) state_nxt = S_DONE;
         end
         S_DONE: begin
            bus.o_done = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Window: W(t) sits in win[0]; each pop shifts in W(t+16) computed from the same window.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < 16; k++) win[k] <= '0;
         ld_cnt <= '0;
         t_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               ld_cnt <= '0;
               t_cnt  <= '0;
            end
            S_LOAD: begin
`ifdef SHA256_SCHED_BULK_LOAD_EN
               if (bus.i_block_valid) begin
                  for (int k = 0; k < 16; k++) win[k] <= bus.i_block[511-32*k -: 32];
               end else
`endif
               if (m_fire) begin
                  for (int k = 0; k < 15; k++) win[k] <= win[k+1];
                  win[15] <= bus.i_m;
                  ld_cnt  <= ld_cnt + 4'd1;
               end
            end
            S_STREAM: begin
               if (pop) begin
                  for (int k = 0; k < 15; k++) win[k] <= win[k+1];
                  win[15] <= w_next;
                  t_cnt   <= t_cnt + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sha256_sched_ctrl.md
Name: sha256_sched_ctrl

Overview:
Sequential SHA-256 message-schedule controller. It accepts one 512-bit block as sixteen 32-bit words and holds them in a 16-entry sliding window. It then streams W0..W63 one word per accepted handshake to the compression-round engine, computing each W(t+16) on the fly. It replaces the fully unrolled W16..W63 expansion with a 16-register window plus one sigma adder tree, under start/load/stream/done sequencing.

Parameters:
ROUNDS, 64, number of schedule words emitted per block; legal range 16..64; the last word emitted is W(ROUNDS-1).

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_start  input  1  begin a new block; sampled only in IDLE
i_m  input  32  message word, big-endian order, W0 first
i_m_valid  input  1  i_m holds a valid word
o_m_ready  output  1  controller accepts i_m this cycle
o_w  output  32  current schedule word W(o_t)
o_w_valid  output  1  o_w/o_t valid
i_w_ready  input  1  round engine consumes o_w this cycle
o_t  output  6  round index of o_w
o_last  output  1  high with o_w_valid when o_t == ROUNDS-1
o_busy  output  1  high in LOAD and STREAM
o_done  output  1  one-cycle pulse after the last word is consumed

Behaviour:
- Reset (i_rst=1 at the edge): state=IDLE; window w[0..15]=0; load/round counters=0; o_m_ready=0, o_w_valid=0, o_last=0, o_busy=0, o_done=0, o_t=0, o_w=0. Reset wins over every other input. Reset mid-LOAD or mid-STREAM discards the partial block with no o_done.
- States: IDLE, LOAD, STREAM, DONE.
- IDLE: if i_start=1, go to LOAD and clear the load counter. i_start outside IDLE is ignored.
- LOAD: o_m_ready=1. On i_m_valid&&o_m_ready: w[15]<=i_m; w[k]<=w[k+1] for k=0..14; increment the counter. After the 16th accepted word, go to STREAM with o_t=0. There is no gap cycle; o_w_valid rises the cycle after the 16th acceptance. i_m_valid without o_m_ready has no effect.
- STREAM: o_w_valid=1, o_w=w[0], o_t=round counter.
  - On o_w_valid&&i_w_ready (pop): shift w[k]<=w[k+1]; w[15]<=sig1(w[14])+w[9]+sig0(w[1])+w[0] mod 2^32; o_t increments.
  - sig0(x)=ROTR7^ROTR18^SHR3; sig1(x)=ROTR17^ROTR19^SHR10.
  - The same update applies for all t, so W(t+16) is produced uniformly. Values computed past W(ROUNDS-1) are unused.
  - i_w_ready=0 holds o_w, o_t and the window stable (backpressure, no loss).
  - o_last=1 iff o_t==ROUNDS-1. A pop with o_last set goes to DONE.
- DONE: o_done=1 for exactly one cycle; o_w_valid=0; then IDLE. i_start in the DONE cycle is ignored.
- o_busy=1 in LOAD and STREAM only.
- Latency: 16 load handshakes, then ROUNDS pop handshakes. The minimum block time is 16+ROUNDS+1 cycles from the first accepted word to the o_done pulse.

Optional Feature:
SHA256_SCHED_BULK_LOAD_EN
- Defined: adds i_block (input, 512) and i_block_valid (input, 1). In LOAD, i_block_valid=1 loads all 16 words in one cycle, w[k]=i_block[511-32k -: 32], and goes to STREAM next cycle. i_block_valid takes priority over i_m_valid in the same cycle.
- Undefined: these ports do not exist; word-serial load only.

Test Plan:
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), i_w_ready=1 -> o_w for t=16..19 = 0x61626380, 0x000F0000, 0x7DA86405, 0x600003C6; 64 words emitted; o_last at o_t=63; o_done one cycle later.
- Same block with i_w_ready toggled 1,0,0,1 pseudo-randomly -> identical W sequence to the previous test; o_w/o_t stable while stalled.
- i_m_valid gaps during LOAD (valid every third cycle) -> exactly 16 words captured; o_w_valid only after the 16th acceptance.
- Assert i_rst at o_t=30 -> next cycle all outputs zero, state IDLE, no o_done. A fresh "abc" block then yields W16=0x61626380.
- i_start pulsed during STREAM and during DONE -> ignored; no second block starts until i_start is seen in IDLE.
- ROUNDS=16 -> emits only the loaded W0..W15, o_last at o_t=15. With SHA256_SCHED_BULK_LOAD_EN, the "abc" i_block loads in 1 cycle with the same W sequence.
